regfile_wb_arbiter: RTL

- Write-side companion to the register file: owns the register file's single write port (WE3/AD3/WD3).
- Arbitrates writeback requests from N_SRC producers (ALU, load unit, mul/div) with round-robin priority and registers the chosen write.
- Keeps a pending-write scoreboard: decode marks a destination at issue, and decode queries whether a source operand is still in flight.

---
 rtl/regfile_wb_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: owns the register file's single write port (WE3/AD3/WD3).
// Round-robin arbitration of N_SRC writeback producers. The chosen write is
// registered for one cycle. A pending-write scoreboard lets decode see which
// registers still have a result in flight.
// Optional build macro: WB_BYPASS_EN adds forwarding of the write-port value
// to decode, one cycle before the register file can return it.
module regfile_wb_arbiter #(
    parameter int N_SRC = 3,
    parameter int XLEN  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_SRC-1:0]      req_valid,
    output logic [N_SRC-1:0]      req_ready,
    input  logic [5*N_SRC-1:0]    req_rd,
    input  logic [XLEN*N_SRC-1:0] req_data,
    input  logic                  issue_valid,
    input  logic [4:0]            issue_rd,
    input  logic [4:0]            query_rs1,
    input  logic [4:0]            query_rs2,
    output logic                  busy_rs1,
    output logic                  busy_rs2,
    output logic [31:0]           pending,
`ifdef WB_BYPASS_EN
    output logic                  byp_hit_rs1,
    output logic                  byp_hit_rs2,
    output logic [XLEN-1:0]       byp_data_rs1,
    output logic [XLEN-1:0]       byp_data_rs2,
`endif
    output logic                  WE3,
    output logic [4:0]            AD3,
    output logic [XLEN-1:0]       WD3
);

    localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gnt_idx;
    logic [PW-1:0]   cand;
    logic            gnt_found;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic [31:0]     pending_nxt;

    logic [4:0]      rd_arr   [N_SRC];
    logic [XLEN-1:0] data_arr [N_SRC];

    // Unpack the flat producer buses so the winner can be selected by index.
    for (genvar g = 0; g < N_SRC; g++) begin : g_unpack
        assign rd_arr[g]   = req_rd[5*g +: 5];
        assign data_arr[g] = req_data[XLEN*g +: XLEN];
    end

    // Round-robin search starting just after the last winner; first valid wins.
    // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
    always_comb begin
        req_ready = '0;
        gnt_found = 1'b0;
        gnt_idx   = ptr;
        cand      = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            cand = PW'((int'(ptr) + k) % N_SRC);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
        if (gnt_found) req_ready[gnt_idx] = 1'b1;
    end

    assign sel_rd   = rd_arr[gnt_idx];
    assign sel_data = data_arr[gnt_idx];

    // Register the granted write. A write to x0 is accepted but never enabled.
    // Anything accepted while rst is high is dropped.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= PW'(N_SRC - 1);
            WE3 <= 1'b0;
            AD3 <= '0;
            WD3 <= '0;
        end else if (gnt_found) begin
            ptr <= gnt_idx;
            WE3 <= (sel_rd != 5'd0);
            AD3 <= sel_rd;
            WD3 <= sel_data;
        end else begin
            WE3 <= 1'b0;
        end
    end

    // Scoreboard next state: clear on write, then set on issue so set wins.
    always_comb begin
        pending_nxt = pending;
        if (WE3) pending_nxt[AD3] = 1'b0;
        if (issue_valid && (issue_rd != 5'd0)) pending_nxt[issue_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) pending <= '0;
        else     pending <= pending_nxt;
    end

`ifdef WB_BYPASS_EN
    // Operand lookup with forwarding from the write port in flight.
    always_comb begin
        byp_hit_rs1  = WE3 && (AD3 == query_rs1) && (query_rs1 != 5'd0);
        byp_hit_rs2  = WE3 && (AD3 == query_rs2) && (query_rs2 != 5'd0);
        byp_data_rs1 = byp_hit_rs1 ? WD3 : '0;
        byp_data_rs2 = byp_hit_rs2 ? WD3 : '0;
        busy_rs1     = pending[query_rs1] && !byp_hit_rs1;
        busy_rs2     = pending[query_rs2] && !byp_hit_rs2;
    end
`else
    // Operand lookup straight from the scoreboard; pending[0] is always 0.
    always_comb begin
        busy_rs1 = pending[query_rs1];
        busy_rs2 = pending[query_rs2];
    end
`endif

endmodule
